mmio_bus_ctrl: RTL and testbench

//  Parametrised memory-mapped bus controller between the bird CPU and its RAM/peripherals.

---
 rtl/mmio_bus_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped bus controller: mirrored RAM plus an 8-word I/O window holding a
// buffered keypad FIFO, display/LED registers and a prescaled compare timer with irq.
module mmio_bus_ctrl #(
  parameter int          RAM_AW        = 8,
  parameter logic [15:0] IO_BASE       = 16'h00F8,
  parameter int          KFIFO_AW      = 2,
  parameter int          TIMER_PRESC   = 50000,
  parameter logic [15:0] DEFAULT_RDATA = 16'hF345,
  parameter              INIT_FILE     = "ram.dat"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [15:0] cpu_rdata,
  input  logic        key_stb,
  input  logic [3:0]  key_code,
  output logic [15:0] disp_data,
  output logic [7:0]  leds,
  output logic        irq
);

  localparam int RAM_DEPTH = 2 ** RAM_AW;
  localparam int KDEPTH    = 2 ** KFIFO_AW;
  localparam int KCW       = KFIFO_AW + 1;
  localparam int PRESC_W   = (TIMER_PRESC > 1) ? $clog2(TIMER_PRESC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TIMER_PRESC - 1);

  localparam logic [2:0] OFF_KEY_DATA   = 3'd0;
  localparam logic [2:0] OFF_KEY_STATUS = 3'd1;
  localparam logic [2:0] OFF_DISP       = 3'd2;
  localparam logic [2:0] OFF_LEDS       = 3'd3;
  localparam logic [2:0] OFF_TCOUNT     = 3'd4;
  localparam logic [2:0] OFF_TCMP       = 3'd5;
  localparam logic [2:0] OFF_IRQ        = 3'd6;

  // storage and architectural registers
  logic [15:0]         ram_r [RAM_DEPTH];
  logic [3:0]          kfifo_r [KDEPTH];
  logic [KFIFO_AW-1:0] wr_ptr_r;
  logic [KFIFO_AW-1:0] rd_ptr_r;
  logic [KCW-1:0]      kcount_r;
  logic                ovf_r;
  logic [15:0]         disp_r;
  logic [7:0]          leds_r;
  logic [15:0]         tcount_r;
  logic [PRESC_W-1:0]  presc_r;
  logic [15:0]         tcmp_r;
  logic                timer_flag_r;
  logic                timer_ie_r;

  // decode and side-effect qualifiers
  logic                io_sel_s;
  logic [2:0]          off_s;
  logic [RAM_AW-1:0]   ram_idx_s;
  logic                wr_ram_s;
  logic                wr_status_s;
  logic                wr_disp_s;
  logic                wr_leds_s;
  logic                wr_tcount_s;
  logic                wr_tcmp_s;
  logic                wr_irq_s;
  logic                fifo_empty_s;
  logic                fifo_full_s;
  logic                pop_s;
  logic                push_s;
  logic                flush_s;
  logic                ovf_set_s;
  logic [3:0]          kcount_lo_s;
  logic [3:0]          key_head_s;
  logic                tick_s;
  logic                match_s;

  // address decode and per-register write strobes
  always_comb begin
    io_sel_s    = (cpu_addr[15:3] == IO_BASE[15:3]);
    off_s       = cpu_addr[2:0];
    ram_idx_s   = cpu_addr[RAM_AW-1:0];
    wr_ram_s    = cpu_we & ~io_sel_s & ~rst;
    wr_status_s = cpu_we & io_sel_s & (off_s == OFF_KEY_STATUS);
    wr_disp_s   = cpu_we & io_sel_s & (off_s == OFF_DISP);
    wr_leds_s   = cpu_we & io_sel_s & (off_s == OFF_LEDS);
    wr_tcount_s = cpu_we & io_sel_s & (off_s == OFF_TCOUNT);
    wr_tcmp_s   = cpu_we & io_sel_s & (off_s == OFF_TCMP);
    wr_irq_s    = cpu_we & io_sel_s & (off_s == OFF_IRQ);
  end

  // keypad FIFO control; a pop frees the slot a same-cycle push lands in when full
  always_comb begin
    fifo_empty_s = (kcount_r == KCW'(0));
    fifo_full_s  = (kcount_r == KCW'(KDEPTH));
    pop_s        = cpu_re & io_sel_s & (off_s == OFF_KEY_DATA) & ~fifo_empty_s;
    push_s       = key_stb & (~fifo_full_s | pop_s);
    ovf_set_s    = key_stb & fifo_full_s & ~pop_s;
    flush_s      = wr_status_s & cpu_wdata[15];
    kcount_lo_s  = 4'(kcount_r);
    key_head_s   = kfifo_r[rd_ptr_r];
  end

  // timer tick and compare match, evaluated on pre-edge state
  always_comb begin
    tick_s  = (presc_r == PRESC_MAX);
    match_s = tick_s & (tcmp_r != 16'h0000) & (tcount_r == tcmp_r);
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ram_s) begin
      ram_r[ram_idx_s] <= cpu_wdata;
    end
  end

  // FIFO storage write; pointer and count updates decide whether it is kept
  always_ff @(posedge clk) begin
    if (push_s) begin
      kfifo_r[wr_ptr_r] <= key_code;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      kcount_r <= '0;
      ovf_r    <= 1'b0;
    end else begin
      if (flush_s) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        kcount_r <= '0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + KFIFO_AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + KFIFO_AW'(1);
        end
        case ({push_s, pop_s})
          2'b10:   kcount_r <= kcount_r + KCW'(1);
          2'b01:   kcount_r <= kcount_r - KCW'(1);
          default: kcount_r <= kcount_r;
        endcase
      end
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (wr_status_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // plain CPU-writable registers
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_r     <= 16'h0000;
      leds_r     <= 8'h00;
      tcmp_r     <= 16'h0000;
      timer_ie_r <= 1'b0;
    end else begin
      if (wr_disp_s) begin
        disp_r <= cpu_wdata;
      end
      if (wr_leds_s) begin
        leds_r <= cpu_wdata[7:0];
      end
      if (wr_tcmp_s) begin
        tcmp_r <= cpu_wdata;
      end
      if (wr_irq_s) begin
        timer_ie_r <= cpu_wdata[8];
      end
    end
  end

  // prescaler, counter and flag; a TCOUNT write beats a tick, a match beats W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r      <= '0;
      tcount_r     <= 16'h0000;
      timer_flag_r <= 1'b0;
    end else begin
      if (wr_tcount_s) begin
        presc_r  <= '0;
        tcount_r <= 16'h0000;
      end else begin
        presc_r <= tick_s ? '0 : presc_r + PRESC_W'(1);
        if (match_s) begin
          tcount_r <= 16'h0000;
        end else if (tick_s) begin
          tcount_r <= tcount_r + 16'h0001;
        end
      end
      if (match_s) begin
        timer_flag_r <= 1'b1;
      end else if (wr_irq_s && cpu_wdata[0]) begin
        timer_flag_r <= 1'b0;
      end
    end
  end

  // combinational read mux
  always_comb begin
    cpu_rdata = ram_r[ram_idx_s];
    if (io_sel_s) begin
      case (off_s)
        OFF_KEY_DATA:   cpu_rdata = {12'h000, fifo_empty_s ? 4'h0 : key_head_s};
        OFF_KEY_STATUS: cpu_rdata = {8'h00, kcount_lo_s, 1'b0, ovf_r, fifo_full_s, ~fifo_empty_s};
        OFF_DISP:       cpu_rdata = disp_r;
        OFF_LEDS:       cpu_rdata = {8'h00, leds_r};
        OFF_TCOUNT:     cpu_rdata = tcount_r;
        OFF_TCMP:       cpu_rdata = tcmp_r;
        OFF_IRQ:        cpu_rdata = {7'b0, timer_ie_r, 7'b0, timer_flag_r};
        default:        cpu_rdata = DEFAULT_RDATA;
      endcase
    end else begin
      cpu_rdata = ram_r[ram_idx_s];
    end
  end

  assign disp_data = disp_r;
  assign leds      = leds_r;
  assign irq       = timer_flag_r & timer_ie_r;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Bench for mmio_bus_ctrl: directed scenarios plus randomized traffic, all
// checked against a queue/array reference model updated once per clock.
module tb_mmio_bus_ctrl;

  localparam logic [15:0] IO_BASE = 16'h00F8;
  localparam int          DEPTH   = 4;
  localparam int          PRESC   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [15:0] cpu_rdata;
  logic        key_stb;
  logic [3:0]  key_code;
  logic [15:0] disp_data;
  logic [7:0]  leds;
  logic        irq;

  always #5 clk = ~clk;

  mmio_bus_ctrl #(
    .RAM_AW(8), .IO_BASE(IO_BASE), .KFIFO_AW(2), .TIMER_PRESC(PRESC),
    .DEFAULT_RDATA(16'hF345), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata),
    .key_stb(key_stb), .key_code(key_code), .disp_data(disp_data),
    .leds(leds), .irq(irq)
  );

  // reference model
  logic [15:0] m_ram [256];
  bit          m_known [256];
  logic [3:0]  m_q [$];
  bit          m_ovf;
  logic [15:0] m_disp;
  logic [7:0]  m_leds;
  logic [15:0] m_tcount;
  logic [15:0] m_tcmp;
  int          m_presc;
  bit          m_flag;
  bit          m_ie;
  bit          m_valid = 1'b0;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] obs_rdata;
  logic [15:0] obs_disp;
  logic        obs_irq;

  localparam logic [15:0] A_KDATA  = IO_BASE + 16'd0;
  localparam logic [15:0] A_STATUS = IO_BASE + 16'd1;
  localparam logic [15:0] A_DISP   = IO_BASE + 16'd2;
  localparam logic [15:0] A_TCOUNT = IO_BASE + 16'd4;
  localparam logic [15:0] A_TCMP   = IO_BASE + 16'd5;
  localparam logic [15:0] A_IRQ    = IO_BASE + 16'd6;
  localparam logic [15:0] A_RSVD   = IO_BASE + 16'd7;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_io(input logic [15:0] a);
    return a[15:3] == IO_BASE[15:3];
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    logic [7:0] cnt;
    cnt = 8'(m_q.size());
    if (!is_io(a)) return m_ram[a[7:0]];
    case (a[2:0])
      3'd0:    return (m_q.size() == 0) ? 16'h0000 : {12'h000, m_q[0]};
      3'd1:    return {8'h00, cnt[3:0], 1'b0, m_ovf, m_q.size() == DEPTH, m_q.size() != 0};
      3'd2:    return m_disp;
      3'd3:    return {8'h00, m_leds};
      3'd4:    return m_tcount;
      3'd5:    return m_tcmp;
      3'd6:    return {7'b0, m_ie, 7'b0, m_flag};
      default: return 16'hF345;
    endcase
  endfunction

  task automatic m_step(input bit r, input logic [15:0] a, input logic [15:0] w,
                        input bit we, input bit re, input bit ks, input logic [3:0] kc);
    bit io, pop, ovf_set, tick, match;
    if (r) begin
      m_q.delete();
      m_ovf = 0; m_disp = '0; m_leds = '0; m_tcount = '0; m_tcmp = '0;
      m_presc = 0; m_flag = 0; m_ie = 0; m_valid = 1'b1;
      return;
    end
    io      = is_io(a);
    pop     = re && io && a[2:0] == 3'd0 && m_q.size() > 0;
    ovf_set = ks && m_q.size() == DEPTH && !pop;
    tick    = (m_presc == PRESC - 1);
    match   = tick && m_tcmp != 16'h0 && m_tcount == m_tcmp;
    m_presc = tick ? 0 : m_presc + 1;
    if (match) m_tcount = 16'h0;
    else if (tick) m_tcount = m_tcount + 16'h1;
    if (pop) void'(m_q.pop_front());
    if (ks && !ovf_set) m_q.push_back(kc);
    if (we && io) begin
      case (a[2:0])
        3'd1: begin if (w[15]) m_q.delete(); m_ovf = 0; end
        3'd2: m_disp = w;
        3'd3: m_leds = w[7:0];
        3'd4: begin m_tcount = 16'h0; m_presc = 0; end
        3'd5: m_tcmp = w;
        3'd6: begin m_ie = w[8]; if (w[0]) m_flag = 0; end
        default: ;
      endcase
    end else if (we) begin
      m_ram[a[7:0]]   = w;
      m_known[a[7:0]] = 1'b1;
    end
    if (ovf_set) m_ovf = 1;
    if (match) m_flag = 1;
  endtask

  // one bus cycle: drive, sample at negedge, compare, advance model, cross posedge
  task automatic cycle(input bit r, input logic [15:0] a, input logic [15:0] w,
                       input bit we, input bit re, input bit ks, input logic [3:0] kc);
    rst = r; cpu_addr = a; cpu_wdata = w; cpu_we = we; cpu_re = re;
    key_stb = ks; key_code = kc;
    @(negedge clk);
    obs_rdata = cpu_rdata;
    obs_disp  = disp_data;
    obs_irq   = irq;
    if (m_valid) begin
      if (is_io(a) || m_known[a[7:0]]) check($sformatf("rdata@%h", a), cpu_rdata, m_read(a));
      check("disp", disp_data, m_disp);
      check("leds", leds, m_leds);
      check("irq", irq, m_flag & m_ie);
    end
    m_step(r, a, w, we, re, ks, kc);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a);
    cycle(1'b0, a, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] w);
    cycle(1'b0, a, w, 1'b1, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic push(input logic [3:0] k);
    cycle(1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b1, k);
  endtask

  task automatic pop_key();
    cycle(1'b0, A_KDATA, 16'h0, 1'b0, 1'b1, 1'b0, 4'h0);
  endtask

  initial begin
    logic [3:0]  tail [4];
    logic [15:0] a, w;
    logic [2:0]  off;
    bit          seen;
    tail = '{4'd2, 4'd3, 4'd4, 4'd9};

    @(posedge clk); #1;
    cycle(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    rd(A_STATUS);
    check("rst_status", obs_rdata, 16'h0000);

    for (int i = 0; i < 256; i++) wr(16'h0100 | 16'(i), 16'($urandom));

    // RAM mirroring and reserved offset
    wr(16'h0010, 16'hBEEF);
    rd(16'h0110); check("mirror_0110", obs_rdata, 16'hBEEF);
    rd(16'hFF10); check("mirror_ff10", obs_rdata, 16'hBEEF);
    rd(A_RSVD);   check("reserved", obs_rdata, 16'hF345);

    // FIFO order, full and overflow
    for (int k = 1; k <= 5; k++) push(4'(k));
    rd(A_STATUS); check("status_full_ovf", obs_rdata, 16'h0047);
    for (int k = 1; k <= 4; k++) begin
      pop_key(); check("fifo_order", obs_rdata, 32'(k));
    end
    pop_key(); check("pop_empty", obs_rdata, 16'h0000);

    // full FIFO with simultaneous push and pop
    wr(A_STATUS, 16'h0000);
    for (int k = 1; k <= 4; k++) push(4'(k));
    cycle(1'b0, A_KDATA, 16'h0, 1'b0, 1'b1, 1'b1, 4'd9);
    check("full_pushpop", obs_rdata, 16'h0001);
    rd(A_STATUS); check("full_pushpop_status", obs_rdata, 16'h0043);
    for (int k = 0; k < 4; k++) begin
      pop_key(); check("full_pushpop_tail", obs_rdata, 32'(tail[k]));
    end

    // flush plus ovf clear
    for (int k = 1; k <= 5; k++) push(4'(k));
    wr(A_STATUS, 16'h8000);
    rd(A_STATUS); check("flush_status", obs_rdata, 16'h0000);

    // timer: state n is the state after the n-th edge following the TCOUNT write
    wr(A_TCMP, 16'd3);
    wr(A_IRQ, 16'h0100);
    wr(A_TCOUNT, 16'h0);
    for (int n = 0; n < 10; n++) begin
      rd(A_TCOUNT);
      check("tcount_seq", obs_rdata, (n < 8) ? 32'(n / 2) : 32'd0);
      check("irq_seq", obs_irq, (n >= 8) ? 32'd1 : 32'd0);
    end
    for (int n = 10; n < 15; n++) rd(A_TCOUNT);
    wr(A_IRQ, 16'h0101);
    rd(A_TCOUNT);
    check("w1c_match_cnt", obs_rdata, 16'h0000);
    check("w1c_match_irq", obs_irq, 1'b1);
    wr(A_IRQ, 16'h0101);
    rd(A_TCOUNT);
    check("w1c_clear_irq", obs_irq, 1'b0);

    // reset mid-operation
    push(4'd6);
    push(4'd7);
    wr(A_DISP, 16'h1234);
    wr(16'h0020, 16'h5A5A);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      rd(A_DISP);
      seen = obs_irq;
    end
    check("irq_before_rst", seen, 1'b1);
    cycle(1'b1, A_DISP, 16'hFFFF, 1'b1, 1'b0, 1'b1, 4'hA);
    rd(A_STATUS);
    check("rst_mid_status", obs_rdata, 16'h0000);
    check("rst_mid_disp", obs_disp, 16'h0000);
    check("rst_mid_irq", obs_irq, 1'b0);
    rd(16'h0020); check("rst_ram_kept", obs_rdata, 16'h5A5A);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        off = ($urandom_range(2, 0) == 0) ? 3'd0 : 3'($urandom_range(7, 0));
        a   = {IO_BASE[15:3], off};
      end else begin
        a = 16'($urandom);
      end
      w = 16'($urandom);
      if (is_io(a) && a[2:0] == 3'd5) w = 16'($urandom_range(6, 0));
      if (is_io(a) && a[2:0] == 3'd1) w[15] = ($urandom_range(3, 0) == 0);
      cycle($urandom_range(199, 0) == 0, a, w, $urandom_range(3, 0) == 0,
            $urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
